// File: rtl/nn_fc_layer_engine_if.sv
// Bundle of weight/bias write ports, input beat stream and result stream
// for one fully-connected layer engine.
interface nn_fc_layer_engine_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int N_IN   = 16,
  parameter int N_OUT  = 8
);
  localparam int B       = N_IN / LANES;
  localparam int WADDR_W = (N_OUT * B > 1) ? $clog2(N_OUT * B) : 1;
  localparam int BADDR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                      w_we;
  logic [WADDR_W-1:0]        w_addr;
  logic [LANES*DATA_W-1:0]   w_wdata;
  logic                      b_we;
  logic [BADDR_W-1:0]        b_addr;
  logic [DATA_W-1:0]         b_wdata;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      busy;

  modport master (
    output w_we, w_addr, w_wdata, b_we, b_addr, b_wdata,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  w_we, w_addr, w_wdata, b_we, b_addr, b_wdata,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/nn_fc_layer_engine.sv
// Fully-connected layer: buffers one input vector, sweeps the weight memory
// through LANES parallel multipliers, then streams N_OUT saturated results.
module nn_fc_lane_mul #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   w,
  input  logic [DATA_W-1:0]   x,
  output logic [2*DATA_W-1:0] p
);
  assign p = $signed({{DATA_W{w[DATA_W-1]}}, w}) * $signed({{DATA_W{x[DATA_W-1]}}, x});
endmodule

module nn_fc_layer_engine #(
  parameter int DATA_W = 8,
  parameter int FRAC   = 4,
  parameter int ACC_W  = 24,
  parameter int N_IN   = 16,
  parameter int LANES  = 8,
  parameter int N_OUT  = 8,
  parameter int RELU   = 1
) (
  input  logic             clk,
  input  logic             rst,
  nn_fc_layer_engine_if.slave bus
);
  localparam int B       = N_IN / LANES;
  localparam int NB      = N_OUT * B;
  localparam int WADDR_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int BADDR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int BEAT_W  = (B > 1) ? $clog2(B) : 1;
  localparam int PW      = 2 * DATA_W;
  localparam int VW      = LANES * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
  state_t state, state_n;

  logic [VW-1:0]                wmem [NB];
  logic [DATA_W-1:0]            bmem [N_OUT];
  logic [B-1:0][VW-1:0]         xbuf;
  logic [N_OUT-1:0][DATA_W-1:0] res;
  logic [BEAT_W-1:0]            beat_cnt, d_beat;
  logic [WADDR_W-1:0]           cnt;
  logic [BADDR_W-1:0]           i_neur, d_neur, out_idx;
  logic [1:0]                   vld_pipe;  // [0] address issued, [1] word returned
  logic [VW-1:0]                w_q;
  logic [LANES-1:0][PW-1:0]     prod;
  logic signed [ACC_W-1:0]      acc, sum, acc_next, pre, shr;
  logic [DATA_W-1:0]            post;
  logic                         acc_in, take_out, beat_last, rd_last;

  assign acc_in    = bus.in_valid && (state == IDLE);
  assign take_out  = bus.out_ready && (state == DRAIN);
  assign beat_last = (beat_cnt == BEAT_W'(B - 1));
  assign rd_last   = vld_pipe[1] && (d_beat == BEAT_W'(B - 1)) && (d_neur == BADDR_W'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid && beat_last) state_n = COMPUTE;
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        if (rd_last) state_n = DRAIN;
      end
      DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = res[out_idx];
        bus.out_last  = (out_idx == BADDR_W'(N_OUT - 1));
        if (bus.out_ready && bus.out_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Storage is deliberately outside reset so weights survive a datapath reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.w_we) wmem[bus.w_addr] <= bus.w_wdata;
    if (state == IDLE && bus.b_we) bmem[bus.b_addr] <= bus.b_wdata;
    if (acc_in) xbuf[beat_cnt] <= bus.in_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    nn_fc_lane_mul #(.DATA_W(DATA_W)) u_mul (
      .w (w_q[k*DATA_W +: DATA_W]),
      .x (xbuf[d_beat][k*DATA_W +: DATA_W]),
      .p (prod[k])
    );
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum = sum + {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
    acc_next = acc + sum;
    pre      = acc_next + ($signed({{(ACC_W-DATA_W){bmem[d_neur][DATA_W-1]}}, bmem[d_neur]}) <<< FRAC);
    shr      = pre >>> FRAC;
    if (shr > SAT_HI)      post = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shr < SAT_LO) post = {1'b1, {(DATA_W-1){1'b0}}};
    else                   post = shr[DATA_W-1:0];
    if (RELU != 0 && post[DATA_W-1]) post = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      cnt      <= '0;
      i_neur   <= '0;
      d_beat   <= '0;
      d_neur   <= '0;
      out_idx  <= '0;
      vld_pipe <= '0;
      w_q      <= '0;
      acc      <= '0;
      res      <= '0;
    end else begin
      w_q      <= wmem[cnt];
      d_beat   <= beat_cnt;
      d_neur   <= i_neur;
      vld_pipe <= {vld_pipe[0], (acc_in && beat_last) || (vld_pipe[0] && cnt != WADDR_W'(NB - 1))};
      // beat_cnt counts input beats in IDLE and issued weight beats in COMPUTE
      if (acc_in || vld_pipe[0])
        beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
      if (vld_pipe[0]) begin
        cnt <= (cnt == WADDR_W'(NB - 1)) ? '0 : cnt + WADDR_W'(1);
        if (beat_last)
          i_neur <= (i_neur == BADDR_W'(N_OUT - 1)) ? '0 : i_neur + BADDR_W'(1);
      end
      if (vld_pipe[1]) begin
        if (d_beat == BEAT_W'(B - 1)) begin
          acc         <= '0;
          res[d_neur] <= post;
        end else begin
          acc <= acc_next;
        end
      end
      if (take_out)
        out_idx <= (out_idx == BADDR_W'(N_OUT - 1)) ? '0 : out_idx + BADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_nn_fc_layer_engine.sv
// Directed bench: two engines (RELU=1 and RELU=0) run in lockstep on the same stimulus.
module tb_nn_fc_layer_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_fc_layer_engine_if #(.DATA_W(8), .LANES(8), .N_IN(16), .N_OUT(8)) bus ();
  nn_fc_layer_engine_if #(.DATA_W(8), .LANES(8), .N_IN(16), .N_OUT(8)) bus0 ();

  assign bus0.w_we      = bus.w_we;
  assign bus0.w_addr    = bus.w_addr;
  assign bus0.w_wdata   = bus.w_wdata;
  assign bus0.b_we      = bus.b_we;
  assign bus0.b_addr    = bus.b_addr;
  assign bus0.b_wdata   = bus.b_wdata;
  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_data   = bus.in_data;
  assign bus0.out_ready = bus.out_ready;

  nn_fc_layer_engine #(.DATA_W(8), .FRAC(4), .ACC_W(24), .N_IN(16), .LANES(8), .N_OUT(8), .RELU(1))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  nn_fc_layer_engine #(.DATA_W(8), .FRAC(4), .ACC_W(24), .N_IN(16), .LANES(8), .N_OUT(8), .RELU(0))
    dut_lin (.clk(clk), .rst(rst), .bus(bus0.slave));

  typedef struct {
    logic [7:0] w, x, b3;   // weight byte, input byte, bias of neuron 3
    logic [7:0] e, e3;      // expected RELU outputs: others / neuron 3
    logic [7:0] l, l3;      // expected linear outputs: others / neuron 3
  } vec_t;
  vec_t tbl [6];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // only < 0: every word gets w; otherwise only that address gets w, rest 0
  task automatic load(input logic [7:0] w, input logic [7:0] b3, input int only);
    for (int a = 0; a < 16; a++) begin
      bus.w_we = 1'b1; bus.w_addr = 4'(a);
      bus.w_wdata = (only < 0 || only == a) ? {8{w}} : 64'h0;
      tick();
    end
    bus.w_we = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus.b_we = 1'b1; bus.b_addr = 3'(j);
      bus.b_wdata = (j == 3) ? b3 : 8'h00;
      tick();
    end
    bus.b_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] x0, input logic [7:0] x1, input string tag);
    int t;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = (b == 0) ? {8{x0}} : {8{x1}};
      while (!bus.in_ready && t < 100) begin tick(); t++; end
      if (t >= 100) chk({tag, "_in_ready_timeout"}, 0, 1);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input logic [7:0] e, input logic [7:0] e3, input logic [7:0] l,
                      input logic [7:0] l3, input int sp, input logic [7:0] esp, input string tag);
    int t;
    logic [7:0] er, el;
    for (int j = 0; j < 8; j++) begin
      t = 0;
      while (!bus.out_valid && t < 100) begin tick(); t++; end
      chk($sformatf("%s_valid%0d", tag, j), bus.out_valid, 1);
      er = (j == sp) ? esp : (j == 3) ? e3 : e;
      el = (j == sp) ? esp : (j == 3) ? l3 : l;
      chk($sformatf("%s_relu_o%0d", tag, j), bus.out_data, er);
      chk($sformatf("%s_lin_o%0d", tag, j), bus0.out_data, el);
      chk($sformatf("%s_last%0d", tag, j), bus.out_last, (j == 7) ? 1 : 0);
      tick();
    end
  endtask

  task automatic latency(input string tag);
    int n;
    n = 1;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk({tag, "_latency"}, n, 18);
  endtask

  initial begin
    logic [7:0] hd;
    logic hl;
    logic stable;
    int beats, t;

    tbl[0] = '{8'h10, 8'h04, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40};
    tbl[1] = '{8'h10, 8'h04, 8'h10, 8'h40, 8'h50, 8'h40, 8'h50};
    tbl[2] = '{8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
    tbl[3] = '{8'h10, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    tbl[4] = '{8'h08, 8'hF8, 8'h20, 8'h00, 8'h00, 8'hC0, 8'hE0};
    tbl[5] = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFE};

    rst = 1'b1;
    bus.w_we = 0; bus.w_addr = '0; bus.w_wdata = '0;
    bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_out_last", bus.out_last, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_out_data", bus.out_data, 0);
    chk("post_rst_lin_in_ready", bus0.in_ready, 1);
    tick();

    for (int v = 0; v < 6; v++) begin
      load(tbl[v].w, tbl[v].b3, -1);
      send(tbl[v].x, tbl[v].x, $sformatf("v%0d", v));
      chk($sformatf("v%0d_busy", v), bus.busy, 1);
      latency($sformatf("v%0d", v));
      recv(tbl[v].e, tbl[v].e3, tbl[v].l, tbl[v].l3, -1, 8'h00, $sformatf("v%0d", v));
      chk($sformatf("v%0d_idle_in_ready", v), bus.in_ready, 1);
    end

    // Beat and neuron addressing: only neuron 5 beat 1 has weights; beats differ
    load(8'h10, 8'h00, 11);
    send(8'h04, 8'h08, "addr");
    recv(8'h00, 8'h00, 8'h00, 8'h00, 5, 8'h40, "addr");

    // Backpressure: hold each beat 5 cycles
    load(8'h10, 8'h00, -1);
    bus.out_ready = 1'b0;
    send(8'h04, 8'h04, "bp");
    t = 0;
    while (!bus.out_valid && t < 100) begin tick(); t++; end
    beats = 0;
    for (int j = 0; j < 8; j++) begin
      stable = 1'b1;
      hd = bus.out_data; hl = bus.out_last;
      for (int c = 0; c < 5; c++) begin
        if (bus.out_data !== hd || bus.out_last !== hl || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
          stable = 1'b0;
        tick();
      end
      chk($sformatf("bp_stable%0d", j), stable, 1);
      chk($sformatf("bp_data%0d", j), hd, 8'h40);
      chk($sformatf("bp_last%0d", j), hl, (j == 7) ? 1 : 0);
      if (bus.out_valid) beats++;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("bp_beats", beats, 8);
    chk("bp_in_ready_after", bus.in_ready, 1);
    chk("bp_valid_after", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // Writes during COMPUTE and DRAIN must be dropped
    send(8'h04, 8'h04, "wb");
    bus.w_we = 1'b1; bus.w_addr = 4'd0; bus.w_wdata = '0;
    bus.b_we = 1'b1; bus.b_addr = 3'd0; bus.b_wdata = 8'h7F;
    for (int c = 0; c < 6; c++) begin bus.w_addr = 4'(c + 2); bus.b_addr = 3'(c); tick(); end
    recv(8'h40, 8'h40, 8'h40, 8'h40, -1, 8'h00, "wb_busy");
    bus.w_we = 1'b0; bus.b_we = 1'b0;
    send(8'h04, 8'h04, "wb2");
    recv(8'h40, 8'h40, 8'h40, 8'h40, -1, 8'h00, "wb_rerun");

    // Mid-COMPUTE reset, then a full vector with retained weights/biases
    load(8'h10, 8'h10, -1);
    send(8'h04, 8'h04, "mr");
    repeat (7) tick();
    chk("mr_busy_before", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    beats = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid || bus0.out_valid) beats++;
      tick();
    end
    chk("mr_no_out_valid", beats, 0);
    send(8'h04, 8'h04, "mr2");
    latency("mr2");
    recv(8'h40, 8'h50, 8'h40, 8'h50, -1, 8'h00, "mr2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nn_fc_layer_engine.md
# nn_fc_layer_engine

Parametrised fully-connected neural-network layer with per-layer weight and bias storage. It receives one input vector as a stream of `LANES`-wide beats and computes `N_OUT` neurons, each `sum(w*x) + bias` in signed fixed point, with saturation and optional ReLU. Results leave as a valid/ready stream, one neuron per beat. It is the multi-lane, handshaked successor of the single-lane layer block, and multiple instances chain output-to-input in the network datapath.

## Interface
- `DATA_W`, 8: signed width of inputs, weights, biases and outputs.
- `FRAC`, 4: fractional bits of every `DATA_W` quantity.
- `ACC_W`, 24: accumulator width. Must be ≥ 2*DATA_W + clog2(N_IN) + 1.
- `N_IN`, 16: inputs per neuron. Must be a multiple of `LANES`.
- `LANES`, 8: parallel multipliers. Also the number of elements per input beat and per weight word.
- `N_OUT`, 8: neurons in the layer.
- `RELU`, 1: 1 clamps negative outputs to 0; 0 gives a linear output.
- Derived: `B = N_IN/LANES` beats per vector; `WADDR_W = clog2(N_OUT*B)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `w_we` in 1: weight write strobe.
- `w_addr` in WADDR_W: weight address, = neuron*B + beat.
- `w_wdata` in LANES*DATA_W: weight word. Lane k sits at bits [(k+1)*DATA_W-1 : k*DATA_W].
- `b_we` in 1: bias write strobe.
- `b_addr` in clog2(N_OUT): bias address.
- `b_wdata` in DATA_W: bias value.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in LANES*DATA_W: input vector beats. Lane packing is the same as `w_wdata`.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DATA_W / `out_last` out 1: result stream. `out_last` marks neuron N_OUT-1.
- `busy` out 1: high in COMPUTE and DRAIN.

## Operation
- The FSM has three states: IDLE, COMPUTE, DRAIN.
- IDLE:
  - `in_ready`=1.
  - Each `in_valid&&in_ready` stores `in_data` into input buffer slot `beat_cnt`, then increments `beat_cnt`.
  - On the handshake with `beat_cnt==B-1`: `beat_cnt`←0, go to COMPUTE.
  - Weight and bias writes are accepted only in IDLE. A write strobe in any other state is ignored and memory is unchanged.
- COMPUTE:
  - `in_ready`=0.
  - Sweeps weight addresses 0..N_OUT*B-1, one per cycle.
  - Weight memory has a synchronous read, so data returns the cycle after the address.
  - Each returned word is multiplied lane-wise against the matching input beat. The LANES signed 2*DATA_W products are summed and added into the accumulator (sign-extended to ACC_W).
  - Accumulator arithmetic wraps modulo 2^ACC_W; the `ACC_W` constraint guarantees no overflow.
  - At a neuron's last beat, the post-processing below runs and the result is written to result slot j.
- Post-processing, per neuron:
  - `acc + (sext(bias) << FRAC)`.
  - Arithmetic shift right by FRAC, truncating toward −inf.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - If `RELU`, negative → 0.
- DRAIN:
  - `out_data`=result[`out_idx`], `out_valid`=1.
  - Each `out_valid&&out_ready` advances `out_idx`.
  - The handshake with `out_idx==N_OUT-1` (`out_last`=1) returns to IDLE with `out_idx`←0.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values:
  - state IDLE, `beat_cnt`=0, `out_idx`=0.
  - `in_ready`=0 while `rst`=1, then 1 on the first cycle after reset.
  - `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.
  - Accumulator and pipeline registers are 0.
- COMPUTE lasts exactly N_OUT*B+1 cycles, which includes the one-cycle read latency.
- `out_valid` rises the cycle after COMPUTE ends.
- Latency from the last input handshake to the first `out_valid` is N_OUT*B+2 cycles. With the defaults this is 18.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `in_ready` rises the cycle after the final output handshake. Back-to-back vectors therefore have no extra bubble beyond that one cycle.
- A weight write at cycle t is visible to a COMPUTE starting at t+1 or later.
- If `rst` is asserted in any state, the block is in IDLE on the next cycle. A partial input vector and all results are discarded, and no `out_valid` is produced.
- `in_valid` outside IDLE is not accepted (`in_ready`=0); the upstream holds its data.

## Test plan
All tests use the defaults (DATA_W=8, FRAC=4, N_IN=16, LANES=8, N_OUT=8).
- Basic MAC: all weights 0x10 (1.0), biases 0, inputs all 0x04 (0.25) → 8 outputs of 0x40 (4.0), `out_last` on the 8th. Latency from the last input handshake to the first `out_valid` is 18 cycles.
- Bias and per-neuron addressing: as the basic MAC case, but bias j = 0x10 for neuron j=3 only → output 3 = 0x50, all others 0x40.
- Saturation and ReLU: weights 0xF0 (−1.0), inputs 0x10, bias 0 → with RELU=1 all outputs 0x00. With RELU=0 all outputs 0x80. Weights 0x10 with inputs 0x7F → 0x7F.
- Backpressure: hold `out_ready`=0 for 5 cycles on each output beat → `out_data`/`out_last` stable throughout, 8 beats total, and `in_ready` low until the final handshake +1.
- Writes while busy: pulse `w_we` with 0x00 data and `b_we` during COMPUTE and DRAIN, then rerun the basic MAC case → results unchanged (0x40).
- Mid-operation reset: assert `rst` 1 cycle at COMPUTE cycle 7 → next cycle IDLE, `busy`=0, no `out_valid`. A following full vector produces correct outputs, and stored weights and biases are retained.
